// File: rtl/isa_pkg.sv
// Shared ISA definitions: opcodes as encoded by the Execute stage.
// Any stage that decodes control_in imports this package.
package isa_pkg;

  typedef logic [3:0] opcode_t;

  localparam opcode_t OP_NOP   = 4'd0;
  localparam opcode_t OP_ADD   = 4'd2;
  localparam opcode_t OP_LOAD  = 4'd12;
  localparam opcode_t OP_STORE = 4'd14;
  localparam opcode_t OP_MOV   = 4'd15;

  function automatic logic is_mem_op(opcode_t op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// Wait-state counter for a memory access.
// tc flags the last allowed cycle before an abort.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = $clog2(MAX_WAIT + 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

  // The edge that would make count reach MAX_WAIT is the abort edge.
  assign tc = (count == W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_access.sv
// Memory stage: issues LOAD/STORE to data memory, stalls upstream,
// and forwards all other results to write-back with 1-cycle latency.
module mem_access
  import isa_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        control_in,
  input  logic [DATA_W-1:0] result_in,
  input  logic [DATA_W-1:0] store_data,
  input  logic [4:0]        dest_index_in,
  input  logic              dest_wr_en_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_index,
  output logic              wb_en,
  output logic              mem_err
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       start;
  logic       tc;
  logic [4:0] idx_q;

  assign start = is_mem_op(control_in);

  wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .en   ((state == ACCESS) && !mem_ready),
    .tc   (tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = ACCESS;
      ACCESS: if (mem_ready || tc) state_nxt = IDLE;
    endcase
  end

  always_comb begin
    stall = (state == ACCESS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      idx_q     <= '0;
      wb_data   <= '0;
      wb_index  <= '0;
      wb_en     <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      wb_en   <= 1'b0;
      mem_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            mem_req   <= 1'b1;
            mem_we    <= (control_in == OP_STORE);
            mem_addr  <= result_in;
            mem_wdata <= store_data;
            idx_q     <= dest_index_in;
          end else begin
            wb_data  <= result_in;
            wb_index <= dest_index_in;
            wb_en    <= dest_wr_en_in && (control_in != OP_NOP);
          end
        end
        ACCESS: begin
          // A completing ready beats a simultaneous timeout.
          if (mem_ready) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
              wb_data  <= mem_rdata;
              wb_index <= idx_q;
              wb_en    <= 1'b1;
            end
          end else if (tc) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a write-back scoreboard.
// Expected write-backs are queued at stimulus time and popped on wb_en.
module tb_mem_access;

  localparam int DW = 16;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [4:0]    i;
  } wb_t;

  logic          clk;
  logic          rst;
  logic [3:0]    control_in;
  logic [DW-1:0] result_in;
  logic [DW-1:0] store_data;
  logic [4:0]    dest_index_in;
  logic          dest_wr_en_in;
  logic          mem_req;
  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic [DW-1:0] mem_rdata;
  logic          stall;
  logic [DW-1:0] wb_data;
  logic [4:0]    wb_index;
  logic          wb_en;
  logic          mem_err;

  int  checks = 0;
  int  errors = 0;
  wb_t sb[$];

  mem_access #(
    .DATA_W  (DW),
    .MAX_WAIT(15)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .control_in   (control_in),
    .result_in    (result_in),
    .store_data   (store_data),
    .dest_index_in(dest_index_in),
    .dest_wr_en_in(dest_wr_en_in),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_ready    (mem_ready),
    .mem_rdata    (mem_rdata),
    .stall        (stall),
    .wb_data      (wb_data),
    .wb_index     (wb_index),
    .wb_en        (wb_en),
    .mem_err      (mem_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] op, input logic [DW-1:0] res,
                       input logic [DW-1:0] sd, input logic [4:0] idx,
                       input logic we);
    control_in    = op;
    result_in     = res;
    store_data    = sd;
    dest_index_in = idx;
    dest_wr_en_in = we;
  endtask

  // Scoreboard side: every wb_en pulse must match the queue head.
  always @(negedge clk) begin
    #1;
    if (!rst && wb_en) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL wb_unexpected: observed data %h idx %0d expected none",
               wb_data, wb_index);
      end
      if (sb.size() > 0) begin
        wb_t e;
        e = sb.pop_front();
        checks++;
        assert ({wb_data, wb_index} === e) else begin
          errors++;
          $error("FAIL wb_data: observed %h/%0d expected %h/%0d",
                 wb_data, wb_index, e.d, e.i);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    drive(4'd0, '0, '0, '0, 1'b0);
    @(negedge clk);
    chk("rst_req",   {31'd0, mem_req}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_wb",    {9'd0, wb_data, wb_index, wb_en, mem_err}, 32'd0);
    chk("rst_mem",   {mem_we, mem_addr, mem_wdata[14:0]}, 32'd0);
    rst = 1'b0;
    tick();

    // ADD
    drive(4'd2, 16'h1234, 16'h0, 5'd5, 1'b1);
    sb.push_back('{d: 16'h1234, i: 5'd5});
    tick();
    chk("add_wben",  {31'd0, wb_en}, 32'd1);
    chk("add_stall", {31'd0, stall}, 32'd0);
    // NOP with write enable must not write back
    drive(4'd0, 16'h5555, 16'h0, 5'd6, 1'b1);
    tick();
    chk("nop_wben", {31'd0, wb_en}, 32'd0);

    // LOAD with three ACCESS cycles
    drive(4'd12, 16'h0040, 16'h0, 5'd7, 1'b1);
    tick();
    drive(4'd0, 16'h0, 16'h0, 5'd0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("ld_req",   {15'd0, mem_req, mem_addr}, {15'd0, 1'b1, 16'h0040});
      chk("ld_we",    {30'd0, mem_we, stall}, 32'd1);
      chk("ld_wben0", {31'd0, wb_en}, 32'd0);
      if (k == 2) begin
        mem_ready = 1'b1;
        mem_rdata = 16'hBEEF;
        sb.push_back('{d: 16'hBEEF, i: 5'd7});
      end
      tick();
    end
    mem_ready = 1'b0;
    chk("ld_done", {30'd0, mem_req, stall}, 32'd0);
    chk("ld_wben", {31'd0, wb_en}, 32'd1);
    tick();
    chk("ld_pulse", {31'd0, wb_en}, 32'd0);

    // STORE, zero-wait
    drive(4'd14, 16'h0010, 16'hA5A5, 5'd8, 1'b1);
    tick();
    drive(4'd0, 16'h0, 16'h0, 5'd0, 1'b0);
    chk("st_req",   {14'd0, mem_req, mem_we, mem_wdata}, {16'h3, 16'hA5A5});
    chk("st_addr",  {16'd0, mem_addr}, 32'h0010);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("st_done", {29'd0, mem_req, stall, wb_en}, 32'd0);

    // ready while idle is ignored
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_ready", {29'd0, mem_req, stall, wb_en}, 32'd0);

    // LOAD timeout after 15 ACCESS cycles
    drive(4'd12, 16'h0020, 16'h0, 5'd4, 1'b1);
    tick();
    drive(4'd0, 16'h0, 16'h0, 5'd0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      chk("to_wait", {30'd0, mem_req, mem_err}, 32'd2);
      tick();
    end
    chk("to_err",   {31'd0, mem_err}, 32'd1);
    chk("to_idle",  {29'd0, mem_req, stall, wb_en}, 32'd0);
    tick();
    chk("to_pulse", {31'd0, mem_err}, 32'd0);

    // ready on the timeout edge wins
    drive(4'd12, 16'h0030, 16'h0, 5'd11, 1'b1);
    tick();
    drive(4'd0, 16'h0, 16'h0, 5'd0, 1'b0);
    for (int k = 0; k < 14; k++) tick();
    chk("race_req", {31'd0, mem_req}, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 16'h5A5A;
    sb.push_back('{d: 16'h5A5A, i: 5'd11});
    tick();
    mem_ready = 1'b0;
    chk("race_err", {30'd0, mem_err, wb_en}, 32'd1);

    // asynchronous reset on second ACCESS cycle
    drive(4'd12, 16'h0050, 16'h0, 5'd3, 1'b1);
    tick();
    drive(4'd0, 16'h0, 16'h0, 5'd0, 1'b0);
    tick();
    chk("ar_busy", {30'd0, mem_req, stall}, 32'd3);
    rst = 1'b1;
    #1;
    chk("ar_drop", {30'd0, mem_req, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 16'hDEAD;
    tick();
    mem_ready = 1'b0;
    chk("ar_nowb", {31'd0, wb_en}, 32'd0);

    // LOAD then ADD held by stall
    drive(4'd12, 16'h0044, 16'h0, 5'd9, 1'b1);
    tick();
    drive(4'd2, 16'h7777, 16'h0, 5'd10, 1'b1);
    chk("b2b_stall", {31'd0, stall}, 32'd1);
    mem_ready = 1'b1;
    mem_rdata = 16'h1111;
    sb.push_back('{d: 16'h1111, i: 5'd9});
    sb.push_back('{d: 16'h7777, i: 5'd10});
    tick();
    mem_ready = 1'b0;
    chk("b2b_ld", {15'd0, wb_en, wb_data}, {15'd0, 1'b1, 16'h1111});
    tick();
    drive(4'd0, 16'h0, 16'h0, 5'd0, 1'b0);
    chk("b2b_add", {15'd0, wb_en, wb_data}, {15'd0, 1'b1, 16'h7777});
    tick();
    chk("b2b_once", {31'd0, wb_en}, 32'd0);

    tick();
    chk("sb_empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameter: DATA_W, 16, datapath and address width.
REQ-002 Parameter: MAX_WAIT, 15, number of ACCESS cycles without mem_ready before abort; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 control_in  input  4  opcode from Execute (NOP=0 .. MOV=15).
REQ-006 result_in  input  DATA_W  Execute result; memory address for LOAD and STORE.
REQ-007 store_data  input  DATA_W  Execute output_reg; write data for STORE.
REQ-008 dest_index_in  input  5  destination register index.
REQ-009 dest_wr_en_in  input  1  Execute destination write enable.
REQ-010 mem_req  output  1  data-memory request, registered.
REQ-011 mem_we  output  1  1 = write (STORE), 0 = read (LOAD).
REQ-012 mem_addr, mem_wdata  output  DATA_W each  address and write data, stable while mem_req=1.
REQ-013 mem_ready  input  1  memory completes the request at this edge.
REQ-014 mem_rdata  input  DATA_W  read data, valid when mem_ready=1.
REQ-015 stall  output  1  upstream holds its outputs while 1; combinational from state only.
REQ-016 wb_data  output  DATA_W;  wb_index  output  5;  wb_en  output  1  (write-back, registered).
REQ-017 mem_err  output  1  one-cycle pulse on timeout abort.

Function
REQ-018 FSM has two states: IDLE and ACCESS; stall = (state == ACCESS).
REQ-019 In IDLE, when control_in is LOAD (12) or STORE (14), the block captures result_in, store_data and dest_index_in at the edge and moves to ACCESS.
REQ-020 In ACCESS: mem_req=1; mem_we=1 for STORE, 0 for LOAD; mem_addr and mem_wdata hold the captured values; all inputs except mem_ready and mem_rdata are ignored.
REQ-021 In IDLE, for any other opcode, at the edge: wb_data<=result_in, wb_index<=dest_index_in, wb_en<=dest_wr_en_in; latency 1 cycle.
REQ-022 A NOP produces wb_en=0 regardless of dest_wr_en_in.
REQ-023 In ACCESS with mem_ready=1 at an edge:
  - LOAD: wb_data<=mem_rdata, wb_index<=captured index, wb_en<=1.
  - STORE: wb_en<=0.
  - In both cases, mem_req<=0 and the FSM returns to IDLE.
REQ-024 mem_ready=1 on the first ACCESS cycle is accepted (zero-wait), giving a minimum LOAD latency of 2 edges from capture to wb_en.
REQ-025 wb_en is a single-cycle pulse per instruction; it is 0 on every cycle spent in ACCESS and on every cycle in which no instruction completes.
REQ-026 A wait counter clears on entry to ACCESS and increments on each ACCESS edge without mem_ready.
REQ-027 On reaching MAX_WAIT: return to IDLE, mem_err=1 for one cycle, wb_en=0, mem_req<=0.
REQ-028 mem_ready and the timeout occurring at the same edge: mem_ready wins, and mem_err stays 0.
REQ-029 mem_ready asserted while in IDLE is ignored.
REQ-030 After return to IDLE, the instruction held upstream is processed at the next edge; no instruction is lost or duplicated.

Reset
REQ-031 rst=1 asynchronously forces the following, including mid-ACCESS: state=IDLE; counter=0; mem_req, mem_we, mem_addr, mem_wdata, wb_data, wb_index, wb_en and mem_err all 0; stall=0.
REQ-032 After rst deasserts, the first edge with a LOAD or STORE opcode starts a normal access.

Structure
REQ-033 Opcode constants NOP..MOV (4-bit, identical to the Execute encoding) live in shared package isa_pkg; FSM state encoding stays local.
REQ-034 The wait counter is sub-module wait_timer (clear, enable, terminal-count output), width = clog2(MAX_WAIT+1).

Verification
REQ-035 ADD: control_in=2, result_in=0x1234, index 5, dest_wr_en_in=1 -> next cycle wb_en=1, wb_data=0x1234, wb_index=5, stall=0.
REQ-036 LOAD: addr 0x0040, mem_ready after 3 ACCESS cycles, mem_rdata=0xBEEF -> mem_req=1 with mem_we=0 and mem_addr=0x0040 for 3 cycles, stall=1, then a single wb_en pulse with wb_data=0xBEEF.
REQ-037 STORE: addr 0x0010, store_data=0xA5A5, zero-wait ready -> one cycle with mem_req=1, mem_we=1, mem_wdata=0xA5A5; wb_en stays 0.
REQ-038 LOAD with mem_ready never asserted, MAX_WAIT=15 -> after 15 ACCESS cycles mem_err pulses once, state=IDLE, wb_en=0.
REQ-039 rst asserted on the 2nd ACCESS cycle of a LOAD -> mem_req and stall drop immediately without waiting for an edge; a later mem_ready produces no wb_en.
REQ-040 Back-to-back LOAD then ADD (ADD held by stall) -> LOAD write-back, then ADD write-back exactly one cycle later, in that order.
